seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
Parametrised iterative shift-add multiplier, the successor to the team's fixed 4x4 registered multiplier. It returns the full 2*WIDTH-bit product, with no truncation. It supports a per-operation signed/unsigned mode and uses valid/ready handshakes on both input and output. It sits between datapath producers and consumers that can tolerate multi-cycle latency in exchange for a single adder of WIDTH+1 bits.

Parameters:
WIDTH, 4, operand width in bits (legal range 2..32).
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous active-low reset.
in_valid  input  1  operand handshake valid.
in_ready  output  1  block can accept operands (IDLE only).
a  input  WIDTH  multiplicand.
b  input  WIDTH  multiplier.
is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with a/b.
out_valid  output  1  product valid.
out_ready  input  1  consumer accepts product.
p  output  2*WIDTH  product.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset, when rst_n=0 at a clk edge:
  - state=IDLE, p=0, out_valid=0, busy=0, in_ready=1, counter=0.
  - Any operation in flight is discarded; no output is produced for it.
  - Reset has priority over all other events.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch a, b and is_signed, then go to RUN with counter=0 and in_ready=0.
  - In signed mode, latch |a| and |b| as WIDTH-bit unsigned magnitudes (2^(WIDTH-1) fits), and latch neg = a[MSB] XOR b[MSB].
  - Unsigned mode: neg=0, magnitudes are a and b.
- RUN:
  - Classic radix-2 shift-add on a 2*WIDTH accumulator {hi,lo}, with lo initialised to |b|.
  - Each cycle: if lo[0]=1, hi += |a| (WIDTH+1-bit sum); then the accumulator shifts right by 1, with the carry entering the MSB.
  - Counter increments each cycle.
  - After exactly WIDTH RUN cycles, go to DONE and load p = neg ? -acc : acc (2*WIDTH-bit two's complement); out_valid=1 at the same edge.
- Latency:
  - The input acceptance edge is E0; out_valid and p are visible after edge E0+WIDTH.
  - Minimum initiation interval is WIDTH+2 cycles (accept, WIDTH RUN cycles, one DONE handshake cycle, return to IDLE).
- DONE:
  - out_valid=1; p is held stable until the handshake completes.
  - On an edge with out_ready=1, set out_valid=0 and go to IDLE; p keeps its last value.
  - in_ready stays 0 throughout DONE, even while out_ready=1.
- in_valid outside IDLE is ignored; a, b and is_signed are don't-care outside the IDLE accept edge.
- out_ready outside DONE is ignored.
- Width rules:
  - Unsigned max: (2^W-1)^2 fits in 2W bits.
  - Signed extremes: (-2^(W-1))^2 = 2^(2W-2) is representable as positive in 2W-bit two's complement; (-2^(W-1))*(2^(W-1)-1) is exact.
  - The product is never truncated or saturated.
- A zero operand still takes the full WIDTH cycles; there is no early termination.
- busy = (state != IDLE), registered.

Test Plan:
1. WIDTH=4, unsigned a=15, b=15, in_valid for 1 cycle, out_ready=1 -> out_valid rises 4 cycles after the accept edge with p=8'hE1 (225); in_ready is low from the accept edge until the return to IDLE.
2. WIDTH=4, signed a=4'b1000 (-8), b=4'b1000 (-8) -> p=8'h40 (+64). Then signed a=-3 (4'hD), b=5 -> p=8'hF1 (-15). Then unsigned a=4'hD, b=5 -> p=8'h41 (65), showing that mode is honoured per operation.
3. Backpressure: complete an operation with out_ready=0 held for 6 cycles -> out_valid stays 1, p is constant, in_ready=0, and a new in_valid pulse is ignored. Raise out_ready for 1 cycle -> out_valid=0, in_ready=1 at the next cycle.
4. Back-to-back: in_valid held high continuously, out_ready=1, operand pairs (3,7), (0,9), (15,1) unsigned -> products 21, 0, 15 delivered in order, each exactly WIDTH+2 cycles apart.
5. Reset mid-operation: accept (15,15), then assert rst_n=0 for one edge on the second RUN cycle -> out_valid=0, p=0, in_ready=1 after that edge, and no product ever appears. A following operation (2,3) returns 6 normally.
6. WIDTH=8 instance: unsigned 255*255 -> p=16'hFE01. Signed -128*127 -> p=16'hC080 (-16256). Latency is 8 cycles.

Source files
------------

// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add multiplier with a full 2*WIDTH-bit product,
// per-operation signed/unsigned mode and valid/ready handshakes on both sides.
module seq_multiplier #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [WIDTH-1:0]     mag_a_q, mag_a_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;

  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   acc_next;

  // Magnitudes are taken as unsigned, so -2^(WIDTH-1) maps to 2^(WIDTH-1) exactly.
  assign a_abs = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_abs = (is_signed && b[WIDTH-1]) ? -b : b;

  assign sum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_a_q} : '0);
  assign acc_next = {sum, lo_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    mag_a_d     = mag_a_q;
    neg_d       = neg_q;
    p_d         = p_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mag_a_d = a_abs;
          lo_d    = b_abs;
          hi_d    = '0;
          neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          cnt_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        hi_d  = acc_next[2*WIDTH-1:WIDTH];
        lo_d  = acc_next[WIDTH-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d     = DONE;
          p_d         = neg_q ? -acc_next : acc_next;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      mag_a_q     <= '0;
      neg_q       <= 1'b0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      mag_a_q     <= mag_a_d;
      neg_q       <= neg_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign p         = p_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: WIDTH=4 and WIDTH=8 instances share clock and reset.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       iv4, ir4, s4, ov4, or4, busy4;
  logic [3:0] a4, b4;
  logic [7:0] p4;

  logic        iv8, ir8, s8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  int nvec = 0;
  int nerr = 0;

  seq_multiplier #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .is_signed(s4), .out_valid(ov4), .out_ready(or4), .p(p4), .busy(busy4)
  );

  seq_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .is_signed(s8), .out_valid(ov8), .out_ready(or8), .p(p8), .busy(busy8)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s,
                      input logic [7:0] exp, input string tag);
    chk({tag, "/ready_idle"}, 16'(ir4), 16'd1);
    a4 = a; b4 = b; s4 = s; iv4 = 1'b1; or4 = 1'b1;
    step();
    iv4 = 1'b0;
    chk({tag, "/ready_low"}, 16'(ir4), 16'd0);
    chk({tag, "/busy"}, 16'(busy4), 16'd1);
    repeat (3) step();
    chk({tag, "/ov_early"}, 16'(ov4), 16'd0);
    step();
    chk({tag, "/ov"}, 16'(ov4), 16'd1);
    chk({tag, "/p"}, 16'(p4), 16'(exp));
    chk({tag, "/ready_done"}, 16'(ir4), 16'd0);
    step();
    chk({tag, "/ov_clr"}, 16'(ov4), 16'd0);
    chk({tag, "/ready_back"}, 16'(ir4), 16'd1);
    chk({tag, "/busy_clr"}, 16'(busy4), 16'd0);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [15:0] exp, input string tag);
    a8 = a; b8 = b; s8 = s; iv8 = 1'b1; or8 = 1'b1;
    step();
    iv8 = 1'b0;
    repeat (7) step();
    chk({tag, "/ov_early"}, 16'(ov8), 16'd0);
    step();
    chk({tag, "/ov"}, 16'(ov8), 16'd1);
    chk({tag, "/p"}, p8, exp);
    step();
    chk({tag, "/ready_back"}, 16'(ir8), 16'd1);
  endtask

  initial begin
    logic [3:0] ba [3];
    logic [3:0] bb [3];
    logic [7:0] bp [3];

    rst_n = 1'b0;
    iv4 = 1'b0; a4 = '0; b4 = '0; s4 = 1'b0; or4 = 1'b0;
    iv8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; or8 = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    chk("rst/p", 16'(p4), 16'd0);
    chk("rst/ov", 16'(ov4), 16'd0);
    chk("rst/ready", 16'(ir4), 16'd1);
    chk("rst/busy", 16'(busy4), 16'd0);

    // Unsigned max and signed/unsigned mode per operation
    run4(4'd15, 4'd15, 1'b0, 8'hE1, "u15x15");
    run4(4'h8,  4'h8,  1'b1, 8'h40, "sm8xm8");
    run4(4'hD,  4'd5,  1'b1, 8'hF1, "sm3x5");
    run4(4'hD,  4'd5,  1'b0, 8'h41, "u13x5");

    // Backpressure: product held while out_ready is low, new operands ignored
    a4 = 4'd5; b4 = 4'd3; s4 = 1'b0; iv4 = 1'b1; or4 = 1'b0;
    step();
    iv4 = 1'b0;
    repeat (4) step();
    chk("bp/ov", 16'(ov4), 16'd1);
    chk("bp/p", 16'(p4), 16'd15);
    for (int i = 0; i < 6; i++) begin
      a4 = 4'd9; b4 = 4'd9; iv4 = (i == 2);
      step();
      chk("bp/hold_ov", 16'(ov4), 16'd1);
      chk("bp/hold_p", 16'(p4), 16'd15);
      chk("bp/hold_ready", 16'(ir4), 16'd0);
    end
    iv4 = 1'b0; or4 = 1'b1;
    step();
    chk("bp/rel_ov", 16'(ov4), 16'd0);
    chk("bp/rel_ready", 16'(ir4), 16'd1);
    chk("bp/rel_p", 16'(p4), 16'd15);

    // Back-to-back with in_valid held high: one product every WIDTH+2 cycles
    ba[0] = 4'd3;  bb[0] = 4'd7; bp[0] = 8'd21;
    ba[1] = 4'd0;  bb[1] = 4'd9; bp[1] = 8'd0;
    ba[2] = 4'd15; bb[2] = 4'd1; bp[2] = 8'd15;
    a4 = ba[0]; b4 = bb[0]; s4 = 1'b0; iv4 = 1'b1; or4 = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      if (i < 2) begin
        a4 = ba[i+1]; b4 = bb[i+1];
      end else begin
        iv4 = 1'b0;
      end
      repeat (3) step();
      chk("b2b/ov_early", 16'(ov4), 16'd0);
      step();
      chk("b2b/ov", 16'(ov4), 16'd1);
      chk("b2b/p", 16'(p4), 16'(bp[i]));
      step();
      chk("b2b/ready", 16'(ir4), 16'd1);
      if (i < 2) step();
    end

    // Reset on the second RUN edge discards the operation
    a4 = 4'd15; b4 = 4'd15; s4 = 1'b0; iv4 = 1'b1; or4 = 1'b1;
    step();
    iv4 = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrst/ov", 16'(ov4), 16'd0);
    chk("mrst/p", 16'(p4), 16'd0);
    chk("mrst/ready", 16'(ir4), 16'd1);
    chk("mrst/busy", 16'(busy4), 16'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mrst/no_out", 16'(ov4), 16'd0);
    end
    run4(4'd2, 4'd3, 1'b0, 8'd6, "post_rst");

    // WIDTH=8 instance
    run8(8'd255, 8'd255, 1'b0, 16'hFE01, "w8_u255");
    run8(8'h80,  8'd127, 1'b1, 16'hC080, "w8_sm128");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
